// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack bus transaction, byte lanes,
// load extension, pipeline stall, misalignment and timeout detection.
module dm_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_ext,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] baddr_q, baddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bwd_q, bwd_d;
  logic [31:0] rext_q, rext_d;
  logic        aerr_q, aerr_d;
  logic        berr_q, berr_d;
  logic [1:0]  lane_q, lane_d;
  logic        lb_q, lb_d;
  logic        lh_q, lh_d;
  logic        sx_q, sx_d;

  logic        is_ld, is_st, sz_b, sz_h, sz_w, sext;
  logic        memop, aligned;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] rsh;
  logic [15:0] half;
  logic [31:0] ext;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    sz_w  = 1'b0;
    sext  = 1'b0;
    case (op)
      OP_LB:  begin is_ld = 1'b1; sz_b = 1'b1; sext = 1'b1; end
      OP_LBU: begin is_ld = 1'b1; sz_b = 1'b1; end
      OP_LH:  begin is_ld = 1'b1; sz_h = 1'b1; sext = 1'b1; end
      OP_LHU: begin is_ld = 1'b1; sz_h = 1'b1; end
      OP_LW:  begin is_ld = 1'b1; sz_w = 1'b1; end
      OP_SB:  begin is_st = 1'b1; sz_b = 1'b1; end
      OP_SH:  begin is_st = 1'b1; sz_h = 1'b1; end
      OP_SW:  begin is_st = 1'b1; sz_w = 1'b1; end
      default: ;
    endcase
  end

  assign memop   = is_ld | is_st;
  assign aligned = ~(sz_h & addr[0]) & ~(sz_w & (addr[1:0] != 2'b00));

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    if (is_st) begin
      unique case (1'b1)
        sz_b: begin
          be_n = 4'b0001 << addr[1:0];
          wd_n = {4{wdata[7:0]}};
        end
        sz_h: begin
          be_n = addr[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane select uses the address latched at accept, not the live input.
  assign rsh  = bus_rdata >> {lane_q, 3'b000};
  assign half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    ext = bus_rdata;
    unique case (1'b1)
      lb_q: ext = {{24{sx_q & rsh[7]}}, rsh[7:0]};
      lh_q: ext = {{16{sx_q & half[15]}}, half};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    baddr_d = baddr_q;
    be_d    = be_q;
    bwd_d   = bwd_q;
    rext_d  = rext_q;
    lane_d  = lane_q;
    lb_d    = lb_q;
    lh_d    = lh_q;
    sx_d    = sx_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && memop) begin
          if (aligned) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_st;
            baddr_d = {addr[31:2], 2'b00};
            be_d    = be_n;
            bwd_d   = wd_n;
            cnt_d   = 8'd0;
            lane_d  = addr[1:0];
            lb_d    = sz_b;
            lh_d    = sz_h;
            sx_d    = sext;
          end else begin
            state_d = ERR;
            aerr_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rext_d = ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
          req_d   = 1'b0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= 32'd0;
      be_q    <= 4'd0;
      bwd_q   <= 32'd0;
      rext_q  <= 32'd0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      lane_q  <= 2'd0;
      lb_q    <= 1'b0;
      lh_q    <= 1'b0;
      sx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      be_q    <= be_d;
      bwd_q   <= bwd_d;
      rext_q  <= rext_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      lane_q  <= lane_d;
      lb_q    <= lb_d;
      lh_q    <= lh_d;
      sx_q    <= sx_d;
    end
  end

  assign stall     = mem_valid & memop &
                     ((state_q == IDLE) | (state_q == REQ));
  assign rdata_ext = rext_q;
  assign addr_err  = aerr_q;
  assign bus_err   = berr_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_be    = be_q;
  assign bus_wdata = bwd_q;

endmodule
